// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two
// requesters, holding operands for a settle interval before capturing the result.
module alu_share_arbiter #(
  parameter int WIDTH         = 8,
  parameter int CTRL_W        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_x,
  input  logic [WIDTH-1:0]  req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_x,
  input  logic [WIDTH-1:0]  req1_y,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_carry,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_x,
  output logic [WIDTH-1:0]  alu_y,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_carry,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic                lastGrant_q, lastGrant_d;
  logic                owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CTRL_W-1:0]   aluCtrl_q, aluCtrl_d;
  logic [WIDTH-1:0]    aluX_q, aluX_d;
  logic [WIDTH-1:0]    aluY_q, aluY_d;
  logic [WIDTH-1:0]    rspOut_q, rspOut_d;
  logic                rspCarry_q, rspCarry_d;
  logic                rsp0Valid_q, rsp0Valid_d;
  logic                rsp1Valid_q, rsp1Valid_d;

  logic sel;
  logic grant0;
  logic grant1;
  logic rspTaken;

  // On a tie the requester that did not win last time is selected.
  assign sel      = (req0_valid && req1_valid) ? ~lastGrant_q : req1_valid;
  assign grant0   = (state_q == IDLE) && req0_valid && !sel;
  assign grant1   = (state_q == IDLE) && req1_valid && sel;
  assign rspTaken = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    aluCtrl_d   = aluCtrl_q;
    aluX_d      = aluX_q;
    aluY_d      = aluY_q;
    rspOut_d    = rspOut_q;
    rspCarry_d  = rspCarry_q;
    rsp0Valid_d = rsp0Valid_q;
    rsp1Valid_d = rsp1Valid_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          aluCtrl_d   = sel ? req1_ctrl : req0_ctrl;
          aluX_d      = sel ? req1_x : req0_x;
          aluY_d      = sel ? req1_y : req0_y;
          owner_d     = sel;
          lastGrant_d = sel;
          cnt_d       = SETTLE_INIT;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rspOut_d    = alu_out;
          rspCarry_d  = alu_carry;
          rsp0Valid_d = !owner_q;
          rsp1Valid_d = owner_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rspTaken) begin
          rsp0Valid_d = 1'b0;
          rsp1Valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lastGrant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      aluCtrl_q   <= '0;
      aluX_q      <= '0;
      aluY_q      <= '0;
      rspOut_q    <= '0;
      rspCarry_q  <= 1'b0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      aluCtrl_q   <= aluCtrl_d;
      aluX_q      <= aluX_d;
      aluY_q      <= aluY_d;
      rspOut_q    <= rspOut_d;
      rspCarry_q  <= rspCarry_d;
      rsp0Valid_q <= rsp0Valid_d;
      rsp1Valid_q <= rsp1Valid_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0Valid_q;
  assign rsp1_valid = rsp1Valid_q;
  assign rsp_out    = rspOut_q;
  assign rsp_carry  = rspCarry_q;
  assign alu_ctrl   = aluCtrl_q;
  assign alu_x      = aluX_q;
  assign alu_y      = aluY_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a scoreboard of expected ALU
// results plus directed checks of arbitration, backpressure, settle and reset.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       req0Valid = 1'b0, req1Valid = 1'b0;
  logic       req0Ready, req1Ready;
  logic [3:0] req0Ctrl = '0, req1Ctrl = '0;
  logic [7:0] req0X = '0, req0Y = '0, req1X = '0, req1Y = '0;
  logic       rsp0Valid, rsp1Valid;
  logic       rsp0Ready = 1'b1, rsp1Ready = 1'b1;
  logic [7:0] rspOut;
  logic       rspCarry;
  logic [3:0] aluCtrl;
  logic [7:0] aluX, aluY, aluOut;
  logic       aluCarry;
  logic       busy;

  logic       sReq0Valid = 1'b0;
  logic       sReq0Ready, sReq1Ready;
  logic [3:0] sReq0Ctrl = '0;
  logic [7:0] sReq0X = '0, sReq0Y = '0;
  logic       sIdleValid = 1'b0;
  logic [3:0] sIdleCtrl = '0;
  logic [7:0] sIdleX = '0, sIdleY = '0;
  logic       sRsp0Valid, sRsp1Valid;
  logic       sRsp0Ready = 1'b0, sRsp1Ready = 1'b1;
  logic [7:0] sRspOut;
  logic       sRspCarry;
  logic [3:0] sAluCtrl;
  logic [7:0] sAluX, sAluY;
  logic [7:0] sAluOut = '0;
  logic       sAluCarry = 1'b0;
  logic       sBusy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int respCount = 0;

  typedef struct {
    logic       owner;
    logic [8:0] res;
  } exp_t;
  exp_t sbQ[$];
  exp_t sbEntry;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU used to close the loop around the shared-ALU ports.
  function automatic logic [8:0] aluModel(logic [3:0] c, logic [7:0] x, logic [7:0] y);
    case (c)
      4'd0:    return {1'b0, x} + {1'b0, y};
      4'd1:    return {(x < y), 8'(x - y)};
      4'd12:   return {1'b0, 7'd0, (x == y)};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  assign {aluCarry, aluOut} = aluModel(aluCtrl, aluX, aluY);

  alu_share_arbiter #(.WIDTH(8), .CTRL_W(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_ctrl(req0Ctrl),
    .req0_x(req0X), .req0_y(req0Y),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_ctrl(req1Ctrl),
    .req1_x(req1X), .req1_y(req1Y),
    .rsp0_valid(rsp0Valid), .rsp0_ready(rsp0Ready),
    .rsp1_valid(rsp1Valid), .rsp1_ready(rsp1Ready),
    .rsp_out(rspOut), .rsp_carry(rspCarry),
    .alu_ctrl(aluCtrl), .alu_x(aluX), .alu_y(aluY),
    .alu_out(aluOut), .alu_carry(aluCarry), .busy(busy)
  );

  alu_share_arbiter #(.WIDTH(8), .CTRL_W(4), .SETTLE_CYCLES(3)) dutSettle (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(sReq0Valid), .req0_ready(sReq0Ready), .req0_ctrl(sReq0Ctrl),
    .req0_x(sReq0X), .req0_y(sReq0Y),
    .req1_valid(sIdleValid), .req1_ready(sReq1Ready), .req1_ctrl(sIdleCtrl),
    .req1_x(sIdleX), .req1_y(sIdleY),
    .rsp0_valid(sRsp0Valid), .rsp0_ready(sRsp0Ready),
    .rsp1_valid(sRsp1Valid), .rsp1_ready(sRsp1Ready),
    .rsp_out(sRspOut), .rsp_carry(sRspCarry),
    .alu_ctrl(sAluCtrl), .alu_x(sAluX), .alu_y(sAluY),
    .alu_out(sAluOut), .alu_carry(sAluCarry), .busy(sBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handoff.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbQ.delete();
    end else begin
      if (req0Valid && req0Ready) sbQ.push_back('{1'b0, aluModel(req0Ctrl, req0X, req0Y)});
      if (req1Valid && req1Ready) sbQ.push_back('{1'b1, aluModel(req1Ctrl, req1X, req1Y)});
      if ((rsp0Valid && rsp0Ready) || (rsp1Valid && rsp1Ready)) begin
        if (sbQ.size() == 0) begin
          checkOutput("sbUnexpectedRsp", 32'd1, 32'd0);
        end else begin
          sbEntry = sbQ.pop_front();
          checkOutput("rspExclusive", {31'd0, rsp0Valid & rsp1Valid}, 32'd0);
          checkOutput("rspOwner", {31'd0, rsp1Valid}, {31'd0, sbEntry.owner});
          checkOutput("rspResult", {23'd0, rspCarry, rspOut}, {23'd0, sbEntry.res});
          respCount++;
        end
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    if (n == 0) begin
      req0Valid = 1'b1; req0Ctrl = c; req0X = x; req0Y = y;
    end else begin
      req1Valid = 1'b1; req1Ctrl = c; req1X = x; req1Y = y;
    end
  endtask

  // n = -1 waits for either requester; returns just after the accept edge.
  task automatic waitAccept(input int n, output int who, output int t);
    bit found = 1'b0;
    who = -1;
    t = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if ((n != 1) && req0Valid && req0Ready) begin who = 0; found = 1'b1; end
      else if ((n != 0) && req1Valid && req1Ready) begin who = 1; found = 1'b1; end
      if (found) t = cyc;
    end
    if (!found) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int who, t, tPrev, tH;
  bit found;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstAluX", {24'd0, aluX}, 32'd0);
    checkOutput("rstAluCtrl", {28'd0, aluCtrl}, 32'd0);
    checkOutput("rstRspOut", {23'd0, rspCarry, rspOut}, 32'd0);
    checkOutput("rstRspValid", {30'd0, rsp1Valid, rsp0Valid}, 32'd0);
    checkOutput("rstSettleBusy", {31'd0, sBusy}, 32'd0);
    rst_n = 1'b1;

    // Single add from requester 0.
    applyStimulus(0, 4'd0, 8'd3, 8'd10);
    waitAccept(0, who, t);
    req0Valid = 1'b0;
    checkOutput("addAluX", {24'd0, aluX}, 32'd3);
    checkOutput("addAluY", {24'd0, aluY}, 32'd10);
    checkOutput("addBusy", {31'd0, busy}, 32'd1);
    checkOutput("addRspEarly", {31'd0, rsp0Valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("addRsp0Valid", {31'd0, rsp0Valid}, 32'd1);
    checkOutput("addRsp1Valid", {31'd0, rsp1Valid}, 32'd0);
    checkOutput("addRspOut", {23'd0, rspCarry, rspOut}, 32'd13);
    @(posedge clk); #1;
    checkOutput("addIdle", {31'd0, busy}, 32'd0);
    checkOutput("addAluXHeld", {24'd0, aluX}, 32'd3);

    // Carry out and 7F+7F from requester 1.
    applyStimulus(1, 4'd0, 8'hFF, 8'h01);
    waitAccept(1, who, t);
    req1Valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("carryRsp1Valid", {31'd0, rsp1Valid}, 32'd1);
    checkOutput("carryRsp0Valid", {31'd0, rsp0Valid}, 32'd0);
    checkOutput("carryResult", {23'd0, rspCarry, rspOut}, 32'h100);
    @(posedge clk);
    applyStimulus(1, 4'd0, 8'h7F, 8'h7F);
    waitAccept(1, who, t);
    req1Valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("ovfResult", {23'd0, rspCarry, rspOut}, 32'h0FE);
    @(posedge clk);

    // Round robin with both requesters continuously valid.
    applyStimulus(0, 4'd1, 8'd14, 8'd7);
    applyStimulus(1, 4'd12, 8'hB3, 8'hB3);
    tPrev = 0;
    for (int k = 0; k < 4; k++) begin
      waitAccept(-1, who, t);
      checkOutput($sformatf("rrGrant%0d", k), who, k % 2);
      if (k > 0) checkOutput($sformatf("rrInterval%0d", k), t - tPrev, 32'd3);
      tPrev = t;
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on requester 0 while requester 1 waits.
    rsp0Ready = 1'b0;
    applyStimulus(0, 4'd0, 8'd3, 8'd10);
    waitAccept(0, who, t);
    req0Valid = 1'b0;
    applyStimulus(1, 4'd1, 8'd9, 8'd4);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpRsp0Valid", {31'd0, rsp0Valid}, 32'd1);
      checkOutput("bpRspOut", {24'd0, rspOut}, 32'd13);
      checkOutput("bpBusy", {31'd0, busy}, 32'd1);
      checkOutput("bpReq1Ready", {31'd0, req1Ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp0Ready = 1'b1;
    @(posedge clk); #1;
    tH = cyc;
    waitAccept(1, who, t);
    req1Valid = 1'b0;
    checkOutput("bpReq1AcceptEdge", t, tH);
    repeat (2) @(posedge clk);
    #1;

    // SETTLE_CYCLES=3: only the ALU value present at the capture edge counts.
    sReq0Valid = 1'b1; sReq0Ctrl = 4'd5; sReq0X = 8'd1; sReq0Y = 8'd2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (sReq0Valid && sReq0Ready) found = 1'b1;
    end
    checkOutput("settleAccept", {31'd0, found}, 32'd1);
    @(posedge clk); #1;
    sReq0Valid = 1'b0;
    checkOutput("settleAluX", {24'd0, sAluX}, 32'd1);
    sAluOut = 8'hAA;
    @(posedge clk); #1;
    checkOutput("settleEarly1", {31'd0, sRsp0Valid}, 32'd0);
    sAluOut = 8'hBB;
    @(posedge clk); #1;
    checkOutput("settleEarly2", {31'd0, sRsp0Valid}, 32'd0);
    sAluOut = 8'h5C;
    sAluCarry = 1'b1;
    @(posedge clk); #1;
    checkOutput("settleValid", {31'd0, sRsp0Valid}, 32'd1);
    checkOutput("settleResult", {23'd0, sRspCarry, sRspOut}, 32'h15C);
    sAluOut = 8'h00;
    sAluCarry = 1'b0;
    @(posedge clk); #1;
    checkOutput("settleHold", {23'd0, sRspCarry, sRspOut}, 32'h15C);
    sRsp0Ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("settleIdle", {31'd0, sBusy}, 32'd0);

    // Reset while requester 1's op is in flight.
    applyStimulus(1, 4'd0, 8'd5, 8'd6);
    waitAccept(1, who, t);
    req1Valid = 1'b0;
    checkOutput("midBusy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstAlu", {28'd0, aluCtrl, 8'd0} | {16'd0, aluX, aluY}, 32'd0);
    checkOutput("midRstRsp", {22'd0, rsp1Valid, rspCarry, rspOut}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(0, 4'd0, 8'd1, 8'd1);
    applyStimulus(1, 4'd0, 8'd2, 8'd2);
    @(negedge clk);
    checkOutput("postRstReady", {30'd0, req1Ready, req0Ready}, 32'd1);
    @(posedge clk); #1;
    req0Valid = 1'b0;
    waitAccept(1, who, t);
    req1Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("sbDrained", sbQ.size(), 32'd0);
    checkOutput("rspCount", respCount, 32'd11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
